frame_sync_stream_mux: RTL and testbench
========================================

FRAME_SYNC_STREAM_MUX -- requirements
Module: frame_sync_stream_mux

Interface
REQ-001 Parameter DATA_W, default 24, pixel data width in bits.
REQ-002 Parameter NUM_IN, default 3, number of input streams; fixed at 3, matching the 0..2 range of sel.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sel  input  2  requested input index from the switch state controller; values 0..2 are valid, 3 is ignored.
REQ-006 s_data  input  NUM_IN*DATA_W  packed input pixels; input i occupies bits [i*DATA_W +: DATA_W].
REQ-007 s_valid  input  NUM_IN  per-input beat valid.
REQ-008 s_ready  output  NUM_IN  per-input beat ready.
REQ-009 s_sof  input  NUM_IN  per-input start-of-frame flag, qualified by valid.
REQ-010 s_eof  input  NUM_IN  per-input end-of-frame flag, qualified by valid.
REQ-011 m_data / m_valid / m_ready / m_sof / m_eof  output/output/input/output/output  DATA_W/1/1/1/1  output stream.
REQ-012 active_sel  output  2  input index currently routed to the output.

Function
REQ-013 A beat transfers on an input or output port when valid and ready are both 1 on a rising clk edge.
REQ-014 The FSM has two states: WAIT_SOF and PASS.
REQ-015 In WAIT_SOF, active_sel loads sel on every cycle in which sel is 0..2; sel=3 leaves active_sel unchanged.
REQ-016 In WAIT_SOF, a selected-input beat with s_sof=0 is dropped: s_ready=1, and the beat is not forwarded.
REQ-017 In WAIT_SOF, a selected-input beat with s_sof=1 is not dropped; its s_ready equals the skid buffer's input ready.
REQ-018 When the beat of REQ-017 transfers, it is forwarded and the FSM enters PASS.
REQ-019 The mux routes by the registered active_sel, so a sel change takes effect at the first SOF beat arriving at least 1 cycle after the change.
REQ-020 In PASS, active_sel is frozen and sel is ignored.
REQ-021 In PASS, every selected-input beat is forwarded, with s_ready equal to the skid buffer's input ready.
REQ-022 In PASS, a transferred beat with s_eof=1 returns the FSM to WAIT_SOF on the next cycle.
REQ-023 A beat with s_sof=1 and s_eof=1 (single-beat frame) transfers, is forwarded, and leaves the FSM in WAIT_SOF.
REQ-024 Non-selected inputs are drained continuously: s_ready=1 and their beats are discarded, so the parallel filters upstream never stall.
REQ-025 The output passes through a 2-entry skid buffer with 1-cycle latency.
REQ-026 The skid buffer sustains one beat per cycle when m_ready=1.
REQ-027 m_data, m_sof and m_eof stay stable while m_valid=1 and m_ready=0.
REQ-028 No beat is lost or duplicated under any m_ready pattern.
REQ-029 The output carries only whole frames: every m_sof is followed by exactly one m_eof before the next m_sof.

Reset
REQ-030 During reset the FSM is in WAIT_SOF, active_sel=0, m_valid=0, and both skid entries are empty.
REQ-031 During reset s_ready=0 on all inputs.
REQ-032 Reset asserted mid-frame discards the partial frame; after release the output resumes only from a fresh SOF beat.
REQ-033 s_ready, including the drain of non-selected inputs, is first allowed to be 1 in the first cycle after reset deasserts.

Configuration
REQ-034 With macro FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN defined, the block adds output frame_cnt (16 bits, reset 0).
REQ-035 frame_cnt increments by 1 on each output transfer with m_eof=1 and wraps from 65535 to 0.
REQ-036 Without FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN, the frame_cnt port and its logic are absent and behaviour is otherwise identical.

Structure
REQ-037 Shared package frame_sync_stream_mux_pkg holds the FSM state enum (WAIT_SOF, PASS), constant NUM_IN=3, and constant SEL_INVALID=2'd3.
REQ-038 The skid buffer is a separate sub-module, axis_skid_buffer, parameterised on width DATA_W+2 (data, sof, eof).

Verification
REQ-039 Reset, then sel=1 with a 4-beat frame on input 1 and m_ready=1: m_data equals the input 1 pixels, m_sof on beat 1, m_eof on beat 4, 1-cycle latency, active_sel=1.
REQ-040 sel changes 0->2 on the 2nd beat of an input-0 frame: the rest of the input-0 frame is forwarded, input-2 beats before its next SOF are dropped, and active_sel changes to 2 only in WAIT_SOF.
REQ-041 sel=3 asserted in WAIT_SOF with active_sel=1: active_sel stays 1, and the next input-1 frame is forwarded.
REQ-042 m_ready toggles 1,0,0,1 during a 6-beat frame: output beats are in order with no loss or duplication, and m_data is stable while stalled.
REQ-043 Reset pulsed for 1 cycle after beat 3 of a 6-beat frame: m_valid=0 the next cycle, and output resumes only at the next SOF.
REQ-044 With FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN defined, 3 complete frames give frame_cnt=3, and 65536 frames wrap frame_cnt to 0.

Source files
------------

// File: rtl/frame_sync_stream_mux_pkg.sv
// Shared types and constants for the frame-synchronous stream mux.
package frame_sync_stream_mux_pkg;

  localparam int unsigned NUM_IN      = 3;
  localparam logic [1:0]  SEL_INVALID = 2'd3;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    PASS     = 1'b1
  } state_t;

endpackage

// File: rtl/frame_sync_stream_mux_if.sv
// Pixel stream bundle with frame markers; LANES streams packed side by side.
interface frame_sync_stream_mux_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned LANES  = 1
);

  logic [LANES*DATA_W-1:0] data;
  logic [LANES-1:0]        valid;
  logic [LANES-1:0]        ready;
  logic [LANES-1:0]        sof;
  logic [LANES-1:0]        eof;

  modport master (output data, output valid, output sof, output eof, input ready);
  modport slave  (input data, input valid, input sof, input eof, output ready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output, registered input ready, 1-cycle latency.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_in_fire;
  logic             w_out_free;

  assign o_ready    = !r_skid_valid;
  assign o_valid    = r_out_valid;
  assign o_data     = r_out_data;
  assign w_in_fire  = i_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || i_ready;

  // Skid entry only fills when a beat arrives while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid  <= w_in_fire;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_data <= r_skid_data;
      end else if (w_in_fire) begin
        r_out_data <= i_data;
      end
    end else if (w_in_fire) begin
      r_skid_data <= i_data;
    end
  end

endmodule

// File: rtl/frame_sync_stream_mux.sv
// Frame-aligned 3:1 stream mux; input switches only take effect at a start of frame.
// Optional frame counter output enabled by FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN.
module frame_sync_stream_mux
  import frame_sync_stream_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned NUM_IN = frame_sync_stream_mux_pkg::NUM_IN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              sel,
  frame_sync_stream_mux_if.slave  s,
  frame_sync_stream_mux_if.master m,
  output logic [1:0]              active_sel
`ifdef FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int unsigned SKID_W = DATA_W + 2;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_active_sel;
  logic [1:0]          w_active_sel_nxt;
  logic                w_fwd;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_valid;
  logic                w_sel_sof;
  logic                w_sel_eof;
  logic                w_skid_in_valid;
  logic                w_skid_in_ready;
  logic                w_skid_out_valid;
  logic [SKID_W-1:0]   w_skid_out_data;

  assign w_sel_data  = s.data[32'(r_active_sel)*DATA_W +: DATA_W];
  assign w_sel_valid = s.valid[r_active_sel];
  assign w_sel_sof   = s.sof[r_active_sel];
  assign w_sel_eof   = s.eof[r_active_sel];

  // Next state; the SOF beat that opens a frame also freezes active_sel.
  always_comb begin
    w_state_nxt      = r_state;
    w_active_sel_nxt = r_active_sel;
    w_fwd            = 1'b0;
    w_sel_ready      = 1'b1;
    case (r_state)
      WAIT_SOF: begin
        w_fwd = w_sel_sof;
        if (w_sel_sof) begin
          w_sel_ready = w_skid_in_ready;
        end
        if (w_sel_valid && w_sel_sof && w_skid_in_ready && !w_sel_eof) begin
          w_state_nxt = PASS;
        end else if (sel != SEL_INVALID) begin
          w_active_sel_nxt = sel;
        end
      end
      PASS: begin
        w_fwd       = 1'b1;
        w_sel_ready = w_skid_in_ready;
        if (w_sel_valid && w_skid_in_ready && w_sel_eof) begin
          w_state_nxt = WAIT_SOF;
        end
      end
      default: w_state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT_SOF;
      r_active_sel <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_sel <= w_active_sel_nxt;
    end
  end

  // Unselected inputs are always drained; nothing is accepted while in reset.
  always_comb begin
    s.ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      s.ready[i] = !reset && ((2'(i) == r_active_sel) ? w_sel_ready : 1'b1);
    end
  end

  assign w_skid_in_valid = w_sel_valid && w_fwd && !reset;

  axis_skid_buffer #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_skid_in_valid),
    .i_data  ({w_sel_data, w_sel_sof, w_sel_eof}),
    .o_ready (w_skid_in_ready),
    .o_valid (w_skid_out_valid),
    .o_data  (w_skid_out_data),
    .i_ready (m.ready)
  );

  assign m.valid    = w_skid_out_valid;
  assign m.data     = w_skid_out_data[SKID_W-1:2];
  assign m.sof      = w_skid_out_data[1];
  assign m.eof      = w_skid_out_data[0];
  assign active_sel = r_active_sel;

`ifdef FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= 16'd0;
    end else if (w_skid_out_valid && m.ready && w_skid_out_data[0]) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_frame_sync_stream_mux.sv
// Directed bench for frame_sync_stream_mux: cycle table plus stall and counter sequences.
module tb_frame_sync_stream_mux;

  localparam int unsigned DW = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [1:0]  active_sel;
`ifdef FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  frame_sync_stream_mux_if #(.DATA_W(DW), .LANES(3)) s_if ();
  frame_sync_stream_mux_if #(.DATA_W(DW), .LANES(1)) m_if ();

  frame_sync_stream_mux #(.DATA_W(DW), .NUM_IN(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .s          (s_if),
    .m          (m_if),
    .active_sel (active_sel)
`ifdef FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  sl;
    logic [2:0]  vl;
    logic [2:0]  so;
    logic [2:0]  eo;
    logic [23:0] d0;
    logic [23:0] d1;
    logic [23:0] d2;
    bit          mr;
    bit          e_mv;
    logic [23:0] e_md;
    bit          e_ms;
    bit          e_me;
    logic [1:0]  e_as;
    logic [2:0]  e_sr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input logic [1:0] sl, input logic [2:0] vl,
                             input logic [2:0] so, input logic [2:0] eo,
                             input logic [23:0] d0, input logic [23:0] d1, input logic [23:0] d2,
                             input bit mr, input bit mv, input logic [23:0] md,
                             input bit ms, input bit me, input logic [1:0] as, input logic [2:0] sr);
    vec_t r;
    r.rst = rst; r.sl = sl; r.vl = vl; r.so = so; r.eo = eo;
    r.d0 = d0; r.d1 = d1; r.d2 = d2; r.mr = mr;
    r.e_mv = mv; r.e_md = md; r.e_ms = ms; r.e_me = me; r.e_as = as; r.e_sr = sr;
    return r;
  endfunction

  task automatic drive_idle();
    s_if.valid = 3'b000;
    s_if.sof   = 3'b000;
    s_if.eof   = 3'b000;
    s_if.data  = '0;
  endtask

`ifdef FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN
  // Back-to-back single-beat frames on input 0, then let the output drain.
  task automatic send_singles(input int n);
    s_if.valid = 3'b001;
    s_if.sof   = 3'b001;
    s_if.eof   = 3'b001;
    repeat (n) @(posedge clk);
    #1 drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (frame_cnt !== exp) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d expected %0d", name, frame_cnt, exp);
    end
  endtask
`endif

  initial begin
    logic [30:0] act;
    logic [30:0] exp;
    int          k;
    int          j;
    logic        prev_stall;
    logic [25:0] prev_out;
    logic [23:0] exp_d;

    reset = 1'b1;
    sel   = 2'd0;
    m_if.ready = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);

    // reset state
    tbl.push_back(v(1,0,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,0,3'b000));
    // frame on input 1 with sel=1, input 0 SOF drained meanwhile
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,0,3'b111));
    tbl.push_back(v(0,1,3'b011,3'b011,3'b000,24'h000F00,24'h100001,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100002,0,1, 1,24'h100001,1,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100003,0,1, 1,24'h100002,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b010,0,24'h100004,0,1, 1,24'h100003,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 1,24'h100004,0,1,1,3'b111));
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,1,3'b111));
    // sel 0 -> 2 in mid input-0 frame
    tbl.push_back(v(0,0,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,0,3'b001,3'b001,3'b000,24'h000001,0,0,1, 0,0,0,0,0,3'b111));
    tbl.push_back(v(0,2,3'b101,3'b100,3'b000,24'h000002,0,24'h200001,1, 1,24'h000001,1,0,0,3'b111));
    tbl.push_back(v(0,2,3'b101,3'b000,3'b001,24'h000003,0,24'h200002,1, 1,24'h000002,0,0,0,3'b111));
    tbl.push_back(v(0,2,3'b100,3'b000,3'b000,0,0,24'h200003,1, 1,24'h000003,0,1,0,3'b111));
    tbl.push_back(v(0,2,3'b100,3'b000,3'b000,0,0,24'h200004,1, 0,0,0,0,2,3'b111));
    tbl.push_back(v(0,2,3'b100,3'b100,3'b000,0,0,24'h200005,1, 0,0,0,0,2,3'b111));
    tbl.push_back(v(0,2,3'b100,3'b000,3'b100,0,0,24'h200006,1, 1,24'h200005,1,0,2,3'b111));
    tbl.push_back(v(0,2,3'b000,3'b000,3'b000,0,0,0,1, 1,24'h200006,0,1,2,3'b111));
    tbl.push_back(v(0,2,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,2,3'b111));
    // sel=3 is ignored in WAIT_SOF
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,2,3'b111));
    tbl.push_back(v(0,3,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,3,3'b011,3'b011,3'b000,24'h00000A,24'h10000A,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,3,3'b010,3'b000,3'b010,0,24'h10000B,0,1, 1,24'h10000A,1,0,1,3'b111));
    tbl.push_back(v(0,3,3'b000,3'b000,3'b000,0,0,0,1, 1,24'h10000B,0,1,1,3'b111));
    tbl.push_back(v(0,3,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,1,3'b111));
    // m_ready 1,0,0,1 during a 6-beat frame
    tbl.push_back(v(0,1,3'b010,3'b010,3'b000,0,24'h100011,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100012,0,1, 1,24'h100011,1,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100013,0,0, 1,24'h100012,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100014,0,0, 1,24'h100012,0,0,1,3'b101));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100014,0,1, 1,24'h100012,0,0,1,3'b101));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100014,0,1, 1,24'h100013,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100015,0,1, 1,24'h100014,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b010,0,24'h100016,0,1, 1,24'h100015,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 1,24'h100016,0,1,1,3'b111));
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,1,3'b111));
    // reset pulse after beat 3, then only a fresh SOF gets through
    tbl.push_back(v(0,1,3'b010,3'b010,3'b000,0,24'h100021,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100022,0,1, 1,24'h100021,1,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100023,0,1, 1,24'h100022,0,0,1,3'b111));
    tbl.push_back(v(1,1,3'b010,3'b000,3'b000,0,24'h100024,0,1, 1,24'h100023,0,0,1,3'b000));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100024,0,1, 0,0,0,0,0,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b000,0,24'h100025,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b000,3'b010,0,24'h100026,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b010,3'b010,3'b010,0,24'h100030,0,1, 0,0,0,0,1,3'b111));
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 1,24'h100030,1,1,1,3'b111));
    tbl.push_back(v(0,1,3'b000,3'b000,3'b000,0,0,0,1, 0,0,0,0,1,3'b111));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      reset      = tbl[i].rst;
      sel        = tbl[i].sl;
      s_if.valid = tbl[i].vl;
      s_if.sof   = tbl[i].so;
      s_if.eof   = tbl[i].eo;
      s_if.data  = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
      m_if.ready = tbl[i].mr;
      @(negedge clk);
      act = {m_if.valid, tbl[i].e_mv ? {m_if.data, m_if.sof, m_if.eof} : 26'd0, active_sel, s_if.ready};
      exp = {tbl[i].e_mv, tbl[i].e_mv ? {tbl[i].e_md, tbl[i].e_ms, tbl[i].e_me} : 26'd0,
             tbl[i].e_as, tbl[i].e_sr};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL row%0d got mv=%0b md=%h sof=%0b eof=%0b as=%0d sr=%b expected mv=%0b md=%h sof=%0b eof=%0b as=%0d sr=%b",
                 i, m_if.valid, m_if.data, m_if.sof, m_if.eof, active_sel, s_if.ready,
                 tbl[i].e_mv, tbl[i].e_md, tbl[i].e_ms, tbl[i].e_me, tbl[i].e_as, tbl[i].e_sr);
      end
    end

    // Two back-to-back 8-beat frames on input 1 under random m_ready.
    k = 0;
    j = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 400 && j < 16; cyc++) begin
      @(posedge clk);
      #1;
      if (k < 16) begin
        s_if.valid = 3'b010;
        s_if.sof   = ((k % 8) == 0) ? 3'b010 : 3'b000;
        s_if.eof   = ((k % 8) == 7) ? 3'b010 : 3'b000;
        s_if.data  = {24'h0, 24'h100040 + 24'(k), 24'h0};
      end else begin
        drive_idle();
      end
      m_if.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!m_if.valid || {m_if.data, m_if.sof, m_if.eof} !== prev_out) begin
          errors++;
          $display("FAIL stall_hold got mv=%0b out=%h expected mv=1 out=%h",
                   m_if.valid, {m_if.data, m_if.sof, m_if.eof}, prev_out);
        end
      end
      if (m_if.valid && m_if.ready) begin
        exp_d = 24'h100040 + 24'(j);
        checks++;
        if ({m_if.data, m_if.sof, m_if.eof} !== {exp_d, 1'((j % 8) == 0), 1'((j % 8) == 7)}) begin
          errors++;
          $display("FAIL stress_beat%0d got data=%h sof=%0b eof=%0b expected data=%h sof=%0b eof=%0b",
                   j, m_if.data, m_if.sof, m_if.eof, exp_d, (j % 8) == 0, (j % 8) == 7);
        end
        j++;
      end
      prev_stall = m_if.valid && !m_if.ready;
      prev_out   = {m_if.data, m_if.sof, m_if.eof};
      if (k < 16 && s_if.ready[1]) k++;
    end
    checks++;
    if (j != 16) begin
      errors++;
      $display("FAIL stress_timeout got %0d beats expected 16", j);
    end

`ifdef FRAME_SYNC_STREAM_MUX_FRAME_CNT_EN
    @(posedge clk);
    #1;
    reset = 1'b1;
    sel   = 2'd0;
    m_if.ready = 1'b1;
    drive_idle();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_cnt("cnt_reset", 16'd0);
    send_singles(3);
    check_cnt("cnt_three", 16'd3);
    send_singles(65532);
    check_cnt("cnt_max", 16'd65535);
    send_singles(1);
    check_cnt("cnt_wrap", 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
